// File: rtl/daisy_chain_spi_master.sv
// SPI master for a daisy chain of 8-bit slaves: sends one LSB-first frame on mosi and
// captures the frame returned from the last slave after RX_DELAY sclk periods.
module daisy_chain_spi_master #(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned RX_DELAY   = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*NUM_SLAVES-1:0] tx_data,
  output logic                    busy,
  output logic                    done,
  output logic [8*NUM_SLAVES-1:0] rx_data,
  output logic                    sclk,
  output logic                    cs,
  output logic                    newd,
  output logic                    mosi,
  input  logic                    miso
);

  localparam int unsigned FB = 8 * NUM_SLAVES;
  localparam int unsigned P  = FB + RX_DELAY;
  localparam int unsigned KW = (P > 2) ? $clog2(P) : 1;
  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [KW-1:0] KLast = KW'(P - 1);
  localparam logic [KW-1:0] KFb   = KW'(FB);
  localparam logic [KW-1:0] KRxd  = KW'(RX_DELAY);
  localparam logic [DW-1:0] DLast = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StDone} state_e;

  state_e        state_q;
  logic [DW-1:0] div_q;
  logic [KW-1:0] k_q;
  logic [FB-1:0] tx_q;

  logic          rise;
  logic [KW-1:0] rise_k;

  // A rising sclk edge starts period rise_k: from SETUP (k=0) or after a low half (k+1).
  always_comb begin
    rise   = 1'b0;
    rise_k = '0;
    if (state_q == StSetup && div_q == DLast) begin
      rise   = 1'b1;
      rise_k = '0;
    end else if (state_q == StShift && div_q == DLast && !sclk && k_q != KLast) begin
      rise   = 1'b1;
      rise_k = k_q + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      k_q     <= '0;
      tx_q    <= '0;
      rx_data <= '0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      newd    <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rise) begin
        sclk <= 1'b1;
        k_q  <= rise_k;
        if (rise_k < KFb) begin
          mosi <= tx_q[0];
          tx_q <= tx_q >> 1;
        end else begin
          mosi <= 1'b0;
        end
        // miso still holds what the chain drove at the previous falling edge
        if (rise_k >= KRxd) begin
          rx_data <= {miso, rx_data[FB-1:1]};
        end
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            tx_q    <= tx_data;
            rx_data <= '0;
            cs      <= 1'b0;
            newd    <= 1'b1;
            busy    <= 1'b1;
            div_q   <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (div_q == DLast) begin
            div_q   <= '0;
            state_q <= StShift;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        StShift: begin
          if (div_q == DLast) begin
            div_q <= '0;
            if (sclk) begin
              sclk <= 1'b0;
            end else if (k_q == KLast) begin
              state_q <= StHold;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        StHold: begin
          if (div_q == DLast) begin
            div_q   <= '0;
            cs      <= 1'b1;
            newd    <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_daisy_chain_spi_master.sv
// Bench for daisy_chain_spi_master: loopback, one-slave and two-slave chains, each checked
// through a scoreboard of expected frames popped when the DUT signals done.
module tb_daisy_chain_spi_master;

  typedef struct {
    logic [31:0] rx;
    int          acc;
    int          lat;
    int          rises;
    int          rbase;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  // Loopback instance: miso tied to mosi
  logic        lb_start = 1'b0;
  logic [15:0] lb_tx = '0;
  logic [15:0] lb_rx;
  logic        lb_busy, lb_done, lb_sclk, lb_cs, lb_newd, lb_mosi;
  int          lb_rises = 0;
  sb_t         lb_sb[$];

  daisy_chain_spi_master #(.NUM_SLAVES(2), .CLK_DIV(2), .RX_DELAY(1)) u_lb (
    .clk(clk), .rst(rst), .start(lb_start), .tx_data(lb_tx), .busy(lb_busy), .done(lb_done),
    .rx_data(lb_rx), .sclk(lb_sclk), .cs(lb_cs), .newd(lb_newd), .mosi(lb_mosi),
    .miso(lb_mosi)
  );

  // One-slave chain
  logic        s1_start = 1'b0;
  logic [7:0]  s1_tx = '0;
  logic [7:0]  s1_rx;
  logic        s1_busy, s1_done, s1_sclk, s1_cs, s1_newd, s1_mosi;
  logic        s1_miso = 1'b0;
  logic [7:0]  s1_sr = '0;
  logic [16:0] s1_log = '0;
  int          s1_rises = 0;
  sb_t         s1_sb[$];

  daisy_chain_spi_master #(.NUM_SLAVES(1), .CLK_DIV(4), .RX_DELAY(9)) u_s1 (
    .clk(clk), .rst(rst), .start(s1_start), .tx_data(s1_tx), .busy(s1_busy), .done(s1_done),
    .rx_data(s1_rx), .sclk(s1_sclk), .cs(s1_cs), .newd(s1_newd), .mosi(s1_mosi),
    .miso(s1_miso)
  );

  always @(negedge s1_sclk) begin
    s1_miso <= s1_sr[0];
    s1_sr   <= {s1_mosi, s1_sr[7:1]};
    s1_log  <= {s1_mosi, s1_log[16:1]};
  end

  // Two-slave chain
  logic        s2_start = 1'b0;
  logic [15:0] s2_tx = '0;
  logic [15:0] s2_rx;
  logic        s2_busy, s2_done, s2_sclk, s2_cs, s2_newd, s2_mosi;
  logic        s2_ma = 1'b0, s2_mb = 1'b0;
  logic [7:0]  s2_sra = '0, s2_srb = '0;
  logic [33:0] s2_log = '0;
  logic        s2_csbad = 1'b0;
  logic        s2_prev_sclk = 1'b0, s2_prev_mosi = 1'b0;
  int          s2_run = 0;
  int          s2_rises = 0;
  sb_t         s2_sb[$];

  daisy_chain_spi_master #(.NUM_SLAVES(2), .CLK_DIV(3), .RX_DELAY(18)) u_s2 (
    .clk(clk), .rst(rst), .start(s2_start), .tx_data(s2_tx), .busy(s2_busy), .done(s2_done),
    .rx_data(s2_rx), .sclk(s2_sclk), .cs(s2_cs), .newd(s2_newd), .mosi(s2_mosi),
    .miso(s2_mb)
  );

  always @(negedge s2_sclk) begin
    s2_ma  <= s2_sra[0];
    s2_sra <= {s2_mosi, s2_sra[7:1]};
    s2_mb  <= s2_srb[0];
    s2_srb <= {s2_ma, s2_srb[7:1]};
    s2_log <= {s2_mosi, s2_log[33:1]};
  end

  always @(posedge lb_sclk) lb_rises <= lb_rises + 1;
  always @(posedge s1_sclk) s1_rises <= s1_rises + 1;
  always @(posedge s2_sclk) s2_rises <= s2_rises + 1;

  // Phase lengths and mosi stability on the two-slave instance
  always @(negedge clk) begin
    if (s2_sclk && (s2_cs || !s2_newd)) s2_csbad = 1'b1;
    if (s2_cs) begin
      s2_run = 0;
    end else if (s2_sclk == s2_prev_sclk) begin
      s2_run++;
    end else begin
      check("s2_phase_len", s2_run, 3);
      if (s2_prev_sclk) check("s2_mosi_on_fall", s2_mosi, s2_prev_mosi);
      s2_run = 1;
    end
    s2_prev_sclk = s2_sclk;
    s2_prev_mosi = s2_mosi;
  end

  // Scoreboard monitors
  always @(negedge clk) begin
    sb_t e;
    if (lb_done) begin
      if (lb_sb.size() == 0) check("lb_done_unexpected", lb_done, 1'b0);
      else begin
        e = lb_sb.pop_front();
        check("lb_rx", lb_rx, e.rx);
        check("lb_latency", cyc - e.acc, e.lat);
        check("lb_rises", lb_rises - e.rbase, e.rises);
      end
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (s1_done) begin
      if (s1_sb.size() == 0) check("s1_done_unexpected", s1_done, 1'b0);
      else begin
        e = s1_sb.pop_front();
        check("s1_rx", s1_rx, e.rx);
        check("s1_latency", cyc - e.acc, e.lat);
        check("s1_rises", s1_rises - e.rbase, e.rises);
      end
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (s2_done) begin
      if (s2_sb.size() == 0) check("s2_done_unexpected", s2_done, 1'b0);
      else begin
        e = s2_sb.pop_front();
        check("s2_rx", s2_rx, e.rx);
        check("s2_latency", cyc - e.acc, e.lat);
        check("s2_rises", s2_rises - e.rbase, e.rises);
      end
    end
  end

  task automatic wait_done(input int sel);
    logic f;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      f = (sel == 0) ? lb_done : (sel == 1) ? s1_done : s2_done;
      if (f) return;
    end
    check("done_timeout", f, 1'b1);
  endtask

  task automatic lb_go(input logic [15:0] d, input bit expect_done);
    @(negedge clk);
    lb_tx    = d;
    lb_start = 1'b1;
    if (expect_done) lb_sb.push_back('{rx: 32'(d), acc: cyc + 1, lat: 2 * 2 + 2 * 2 * 17,
                                      rises: 17, rbase: lb_rises});
    @(negedge clk);
    lb_start = 1'b0;
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_lb_ctl", {lb_cs, lb_newd, lb_sclk, lb_mosi, lb_busy, lb_done}, 6'b100000);
    check("rst_lb_rx", lb_rx, 0);
    check("rst_s1_ctl", {s1_cs, s1_newd, s1_sclk, s1_mosi, s1_busy, s1_done}, 6'b100000);
    check("rst_s2_ctl", {s2_cs, s2_newd, s2_sclk, s2_mosi, s2_busy, s2_done}, 6'b100000);

    // Abort in period k=5
    base = lb_rises;
    lb_go(16'hA5C3, 1'b0);
    for (int i = 0; i < 200 && (lb_rises - base) < 6; i++) @(negedge clk);
    check("mid_rst_reached_k5", lb_rises - base, 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ctl", {lb_cs, lb_sclk, lb_busy, lb_done}, 4'b1000);
    check("mid_rst_rx", lb_rx, 0);
    repeat (80) @(negedge clk);
    check("mid_rst_no_done", lb_done, 1'b0);

    // Loopback
    lb_go(16'hA5C3, 1'b1);
    wait_done(0);

    // Handshake: start while busy and in the done cycle are ignored
    lb_go(16'h1234, 1'b1);
    repeat (10) @(negedge clk);
    lb_tx    = 16'hFFFF;
    lb_start = 1'b1;
    @(negedge clk);
    lb_start = 1'b0;
    wait_done(0);
    lb_tx    = 16'h0F0F;
    lb_start = 1'b1;
    @(negedge clk);
    check("hs_done_start_ignored", lb_busy, 1'b0);
    check("hs_rx_hold", lb_rx, 16'h1234);
    lb_sb.push_back('{rx: 32'h0F0F, acc: cyc + 1, lat: 72, rises: 17, rbase: lb_rises});
    @(negedge clk);
    lb_start = 1'b0;
    check("hs_accept_busy", lb_busy, 1'b1);
    wait_done(0);

    // One-slave chain
    @(negedge clk);
    s1_tx    = 8'h96;
    s1_start = 1'b1;
    s1_sb.push_back('{rx: 32'h96, acc: cyc + 1, lat: 2 * 4 + 2 * 4 * 17, rises: 17,
                      rbase: s1_rises});
    @(negedge clk);
    s1_start = 1'b0;
    wait_done(1);
    check("s1_mosi_order", s1_log[7:0], 8'b1001_0110);
    check("s1_mosi_tail", s1_log[16:8], 0);

    // Two-slave chain with tx_data changed mid-frame
    @(negedge clk);
    s2_tx    = 16'h3C81;
    s2_start = 1'b1;
    s2_sb.push_back('{rx: 32'h3C81, acc: cyc + 1, lat: 2 * 3 + 2 * 3 * 34, rises: 34,
                      rbase: s2_rises});
    @(negedge clk);
    s2_start = 1'b0;
    repeat (20) @(negedge clk);
    s2_tx = 16'hFFFF;
    wait_done(2);
    check("s2_tx_frame", s2_log[15:0], 16'h3C81);
    check("s2_tx_tail", s2_log[33:16], 0);
    check("s2_cs_newd_frame", s2_csbad, 1'b0);
    @(negedge clk);
    check("s2_busy_drop", s2_busy, 1'b0);
    check("sb_drained", lb_sb.size() + s1_sb.size() + s2_sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
